// File: rtl/sensor_window.sv
// sensor_window: packs framed 16-bit glove samples into channel vectors.
// It keeps a DEPTH-vector history and hands the flattened window to the core.
// Ports:
//   i_clk              clock
//   i_rst_n            reset, synchronous, active-low
//   i_valid            sample beat is valid
//   i_sample           signed 16-bit sample
//   i_last             last channel of a timestep (used only with i_valid)
//   i_ready            core is idle and can take a window
//   o_data             window, word t*CHANNELS+c, t=0 is the oldest timestep
//   o_next             one-cycle pulse: o_data holds a new window
//   o_err              one-cycle pulse: a vector was dropped for bad framing
//   o_filled           history holds DEPTH valid vectors
// Option: define SENSOR_WINDOW_CALIB_EN to calibrate per-channel offsets.
module sensor_window #(
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 5,
  parameter int STRIDE   = 1,
  parameter int CAL_VECS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_sample,
  input  logic        i_last,
  input  logic        i_ready,
  output logic [15:0] o_data [0:CHANNELS*DEPTH-1],
  output logic        o_next,
  output logic        o_err,
  output logic        o_filled
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STRIDE + 1);

  localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);
  localparam logic [FW-1:0] LAST_FILL = FW'(DEPTH - 1);
  localparam logic [SW-1:0] LAST_STR  = SW'(STRIDE - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1
`ifdef SENSOR_WINDOW_CALIB_EN
    , S_CAL = 2'd2
`endif
  } state_t;

`ifdef SENSOR_WINDOW_CALIB_EN
  localparam state_t S_INIT = S_CAL;
`else
  localparam state_t S_INIT = S_FILL;
`endif

  state_t state;
  state_t state_d;

  logic [CW-1:0] cnt;
  logic [15:0]   stage [0:CHANNELS-1];
  logic [15:0]   entry [0:CHANNELS-1];
  logic [15:0]   hist  [0:DEPTH-1][0:CHANNELS-1];

  // done: a clean vector sits in stage and is consumed next cycle
  logic          done;
  logic          pending;
  logic          pending_d;
  logic [FW-1:0] fill_cnt;
  logic [FW-1:0] fill_d;
  logic [SW-1:0] stride_cnt;
  logic [SW-1:0] stride_d;
  logic          filled_d;
  logic          emit;
  logic          hist_we;

`ifdef SENSOR_WINDOW_CALIB_EN
  localparam int CAL_SH = $clog2(CAL_VECS);
  localparam int CALW   = (CAL_SH > 0) ? CAL_SH : 1;
  localparam logic [CALW-1:0] LAST_CAL = CALW'(CAL_VECS - 1);

  logic [CALW-1:0] cal_cnt;
  logic [23:0]     sums   [0:CHANNELS-1];
  logic [23:0]     sum_nx [0:CHANNELS-1];
  logic [15:0]     offs   [0:CHANNELS-1];
  logic            cal_we;
  logic            cal_done;

  function automatic logic [15:0] sat_sub(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    // sign bits disagree only on overflow
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7fff;
    return d[15:0];
  endfunction

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum_nx[c] = sums[c] + {{8{stage[c][15]}}, stage[c]};
      entry[c]  = sat_sub(stage[c], offs[c]);
    end
  end
`else
  logic unused_cal;
  assign unused_cal = (CAL_VECS == 0);

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      entry[c] = stage[c];
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_INIT;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    pending_d = pending;
    fill_d    = fill_cnt;
    stride_d  = stride_cnt;
    filled_d  = o_filled;
    hist_we   = 1'b0;
`ifdef SENSOR_WINDOW_CALIB_EN
    cal_we    = 1'b0;
    cal_done  = 1'b0;
`endif
    // emission reads history before any shift in this cycle
    emit = pending & i_ready;
    if (emit) pending_d = 1'b0;
    if (done) begin
      unique case (state)
        S_FILL: begin
          hist_we = 1'b1;
          if (fill_cnt == LAST_FILL) begin
            state_d   = S_RUN;
            filled_d  = 1'b1;
            pending_d = 1'b1;
            stride_d  = '0;
          end else begin
            fill_d = fill_cnt + 1'b1;
          end
        end
        S_RUN: begin
          hist_we = 1'b1;
          if (stride_cnt == LAST_STR) begin
            pending_d = 1'b1;
            stride_d  = '0;
          end else begin
            stride_d = stride_cnt + 1'b1;
          end
        end
`ifdef SENSOR_WINDOW_CALIB_EN
        S_CAL: begin
          cal_we = 1'b1;
          if (cal_cnt == LAST_CAL) begin
            cal_done = 1'b1;
            state_d  = S_FILL;
          end
        end
`endif
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      done       <= 1'b0;
      pending    <= 1'b0;
      fill_cnt   <= '0;
      stride_cnt <= '0;
      o_next     <= 1'b0;
      o_err      <= 1'b0;
      o_filled   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        stage[c] <= '0;
      end
      for (int t = 0; t < DEPTH; t++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          hist[t][c]               <= '0;
          o_data[t*CHANNELS + c]   <= '0;
        end
      end
    end else begin
      pending    <= pending_d;
      fill_cnt   <= fill_d;
      stride_cnt <= stride_d;
      o_filled   <= filled_d;
      o_next     <= emit;
      done       <= 1'b0;
      o_err      <= 1'b0;

      if (i_valid) begin
        stage[cnt] <= i_sample;
        if (i_last && cnt == LAST_CH) begin
          done <= 1'b1;
          cnt  <= '0;
        end else if (i_last || cnt == LAST_CH) begin
          o_err <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (emit) begin
        for (int t = 0; t < DEPTH; t++) begin
          for (int c = 0; c < CHANNELS; c++) begin
            o_data[t*CHANNELS + c] <= hist[t][c];
          end
        end
      end

      if (hist_we) begin
        for (int t = 0; t < DEPTH-1; t++) begin
          hist[t] <= hist[t+1];
        end
        for (int c = 0; c < CHANNELS; c++) begin
          hist[DEPTH-1][c] <= entry[c];
        end
      end
    end
  end

`ifdef SENSOR_WINDOW_CALIB_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cal_cnt <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sums[c] <= '0;
        offs[c] <= '0;
      end
    end else if (cal_we) begin
      cal_cnt <= cal_cnt + 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        sums[c] <= sum_nx[c];
        // arithmetic shift of the sum, truncated to a 16-bit offset
        if (cal_done) offs[c] <= sum_nx[c][CAL_SH +: 16];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sensor_window.sv
// tb_sensor_window: directed and random stimulus for sensor_window,
// checked every cycle against a queue-based window model.
module tb_sensor_window;

  localparam int CH = 8;
  localparam int DP = 5;
  localparam int ST = 1;
  localparam int NW = CH * DP;
`ifdef SENSOR_WINDOW_CALIB_EN
  localparam int CALV = 16;
`else
  localparam int CALV = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_sample = '0;
  logic        i_last = 1'b0;
  logic        i_ready = 1'b1;
  logic [15:0] o_data [0:NW-1];
  logic        o_next;
  logic        o_err;
  logic        o_filled;

  sensor_window #(
    .CHANNELS(CH),
    .DEPTH(DP),
    .STRIDE(ST),
    .CAL_VECS(16)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .i_sample(i_sample),
    .i_last(i_last),
    .i_ready(i_ready),
    .o_data(o_data),
    .o_next(o_next),
    .o_err(o_err),
    .o_filled(o_filled)
  );

  always #5 i_clk = ~i_clk;

  int nchk = 0;
  int nfail = 0;
  int npulse = 0;
  bit rand_rdy = 1'b0;

  logic [15:0] win[$];
  logic [15:0] shown [NW];
  logic [15:0] cur[$];
  logic [15:0] arr[$];
  bit          arr_v;
  int          nvec;
  int          scnt;
  bit          m_pend;
  bit          m_fill;
  bit          e_next;
  bit          e_err;
  int          cal_left;
  int          sums [CH];
  int          offs [CH];
  logic [15:0] vec [CH];

  function automatic logic [15:0] calib(int c, logic [15:0] s);
    int d;
    d = int'($signed(s)) - offs[c];
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    return 16'(d);
  endfunction

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < NW; i++) begin
      win.push_back(16'h0);
      shown[i] = 16'h0;
    end
    cur.delete();
    arr.delete();
    arr_v = 1'b0;
    nvec = 0;
    scnt = 0;
    m_pend = 1'b0;
    m_fill = 1'b0;
    e_next = 1'b0;
    e_err = 1'b0;
    cal_left = CALV;
    for (int c = 0; c < CH; c++) begin
      sums[c] = 0;
      offs[c] = 0;
    end
  endtask

  task automatic model_edge(bit v, logic [15:0] s, bit l, bit rdy, bit rst_n);
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_next = 1'b0;
    e_err = 1'b0;
    if (m_pend && rdy) begin
      e_next = 1'b1;
      m_pend = 1'b0;
      for (int i = 0; i < NW; i++) shown[i] = win[i];
    end
    if (arr_v) begin
      arr_v = 1'b0;
      if (cal_left > 0) begin
        for (int c = 0; c < CH; c++) sums[c] += int'($signed(arr[c]));
        cal_left--;
        if (cal_left == 0) begin
          for (int c = 0; c < CH; c++) offs[c] = sums[c] >>> 4;
        end
      end else begin
        for (int c = 0; c < CH; c++) begin
          win.push_back(calib(c, arr[c]));
          void'(win.pop_front());
        end
        if (nvec < DP) begin
          nvec++;
          if (nvec == DP) begin
            m_fill = 1'b1;
            m_pend = 1'b1;
            scnt = 0;
          end
        end else begin
          scnt++;
          if (scnt == ST) begin
            m_pend = 1'b1;
            scnt = 0;
          end
        end
      end
    end
    if (v) begin
      cur.push_back(s);
      if (l && cur.size() == CH) begin
        arr = cur;
        arr_v = 1'b1;
        cur.delete();
      end else if (l || cur.size() == CH) begin
        e_err = 1'b1;
        cur.delete();
      end
    end
  endtask

  task automatic chk1(string tag, logic got, logic exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got %0b exp %0b", tag, got, exp);
    end
  endtask

  task automatic chk16(string tag, logic [15:0] got, logic [15:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chkint(string tag, int got, int exp);
    nchk++;
    assert (got == exp) else begin
      nfail++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    bit ok;
    int bi;
    ok = 1'b1;
    bi = 0;
    chk1("o_next", o_next, e_next);
    chk1("o_err", o_err, e_err);
    chk1("o_filled", o_filled, m_fill);
    for (int i = 0; i < NW; i++) begin
      if (ok && o_data[i] !== shown[i]) begin
        ok = 1'b0;
        bi = i;
      end
    end
    nchk++;
    assert (ok) else begin
      nfail++;
      $error("FAIL o_data[%0d] got %h exp %h", bi, o_data[bi], shown[bi]);
    end
  endtask

  task automatic tick(bit v, logic [15:0] s, bit l);
    i_valid = v;
    i_sample = s;
    i_last = l;
    if (rand_rdy) i_ready = ($urandom_range(9, 0) < 7);
    @(posedge i_clk);
    #1;
    model_edge(v, s, l, i_ready, i_rst_n);
    if (o_next) npulse++;
    check_all();
  endtask

  task automatic idle(int n);
    repeat (n) tick(1'b0, 16'($urandom), 1'($urandom_range(1, 0)));
  endtask

  task automatic set_vec(int base);
    for (int c = 0; c < CH; c++) vec[c] = 16'(base + c);
  endtask

  // li: beat index carrying i_last, -1 for none
  task automatic send_vec(int nb, int li, int gap);
    for (int b = 0; b < nb; b++) begin
      tick(1'b1, vec[b % CH], b == li);
      if (gap > 0 && b != nb - 1) idle($urandom_range(gap, 0));
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick(1'b0, 16'h0, 1'b0);
    i_rst_n = 1'b1;
  endtask

  task automatic cal_zero();
`ifdef SENSOR_WINDOW_CALIB_EN
    for (int c = 0; c < CH; c++) vec[c] = 16'h0;
    repeat (16) send_vec(CH, CH - 1, 0);
`endif
  endtask

  initial begin
    model_reset();
    i_rst_n = 1'b0;
    tick(1'b0, 16'h0, 1'b0);
    tick(1'b0, 16'h0, 1'b0);
    chk1("rst_next", o_next, 1'b0);
    chk1("rst_filled", o_filled, 1'b0);
    chk16("rst_d0", o_data[0], 16'h0);
    i_rst_n = 1'b1;
    cal_zero();

    npulse = 0;
    for (int t = 0; t < 5; t++) begin
      set_vec(100 * t);
      send_vec(CH, CH - 1, 0);
    end
    chk1("lat0", o_next, 1'b0);
    idle(1);
    chk1("lat1", o_next, 1'b0);
    idle(1);
    chk1("lat2", o_next, 1'b1);
    chk16("fill_w0", o_data[0], 16'd0);
    chk16("fill_w9", o_data[9], 16'd101);
    chk16("fill_w39", o_data[39], 16'd407);
    chk1("fill_filled", o_filled, 1'b1);
    chkint("fill_pulses", npulse, 1);

    set_vec(600);
    send_vec(CH, CH - 1, 0);
    idle(2);
    chk1("v6_next", o_next, 1'b1);
    chk16("v6_w0", o_data[0], 16'd100);
    chk16("v6_w32", o_data[32], 16'd600);

    npulse = 0;
    set_vec(700);
    send_vec(5, 4, 0);
    chk1("err_short", o_err, 1'b1);
    idle(3);
    set_vec(750);
    send_vec(CH, -1, 0);
    chk1("err_nolast", o_err, 1'b1);
    idle(3);
    chkint("err_no_next", npulse, 0);
    set_vec(800);
    send_vec(CH, CH - 1, 0);
    idle(2);
    chk1("v8_next", o_next, 1'b1);
    chk16("v8_w0", o_data[0], 16'd200);
    chk16("v8_w24", o_data[24], 16'd600);
    chk16("v8_w32", o_data[32], 16'd800);

    i_ready = 1'b0;
    npulse = 0;
    for (int k = 9; k < 12; k++) begin
      set_vec(k * 100);
      send_vec(CH, CH - 1, 1);
    end
    idle(3);
    chk16("bp_hold", o_data[32], 16'd800);
    chkint("bp_none", npulse, 0);
    i_ready = 1'b1;
    idle(3);
    chkint("bp_one", npulse, 1);
    chk16("bp_w0", o_data[0], 16'd600);
    chk16("bp_w32", o_data[32], 16'd1100);

    set_vec(1200);
    send_vec(3, -1, 0);
    do_reset();
    chk1("mrst_next", o_next, 1'b0);
    chk1("mrst_err", o_err, 1'b0);
    chk1("mrst_filled", o_filled, 1'b0);
    chk16("mrst_d0", o_data[0], 16'h0);
    chk16("mrst_d39", o_data[39], 16'h0);
    cal_zero();
    npulse = 0;
    for (int t = 0; t < 4; t++) begin
      set_vec(2000 + 100 * t);
      send_vec(CH, CH - 1, 0);
    end
    idle(4);
    chkint("refill_none", npulse, 0);
    set_vec(2400);
    send_vec(CH, CH - 1, 0);
    idle(2);
    chk1("refill_next", o_next, 1'b1);
    chkint("refill_one", npulse, 1);
    chk16("refill_w0", o_data[0], 16'd2000);

    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int r;
      int len;
      for (int c = 0; c < CH; c++) vec[c] = 16'($urandom);
      r = $urandom_range(9, 0);
      if (r == 0) begin
        len = $urandom_range(7, 1);
        send_vec(len, len - 1, 2);
      end else if (r == 1) begin
        send_vec(CH, -1, 2);
      end else begin
        send_vec(CH, CH - 1, 2);
      end
      idle($urandom_range(3, 0));
    end
    rand_rdy = 1'b0;
    i_ready = 1'b1;
    idle(4);

`ifdef SENSOR_WINDOW_CALIB_EN
    do_reset();
    for (int c = 0; c < CH; c++) vec[c] = 16'd55;
    vec[0] = 16'd1000;
    vec[7] = 16'hfffb;
    repeat (16) send_vec(CH, CH - 1, 0);
    vec[0] = 16'h8300;
    repeat (5) send_vec(CH, CH - 1, 0);
    idle(2);
    chk1("cal_next", o_next, 1'b1);
    chk16("cal_sat", o_data[32], 16'h8000);
    chk16("cal_flat", o_data[33], 16'h0);
    chk16("cal_neg", o_data[39], 16'h0);
`endif

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
